// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register file and its write-back queue.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int DATA_W   = 32;

  // One pending register write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wbq_fifo.sv
// In-order storage for pending register writes.
// Pointers carry an extra wrap bit, so full and empty are distinguished by
// the pointer difference alone. A per-entry valid vector and the stored
// addresses are exported so the parent can match pending writes.
module wbq_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  output logic [DEPTH*ADDR_W-1:0]    entry_addr,
  output logic [DEPTH-1:0]           entry_vld,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] rel    [DEPTH];

  // Next pointer values: advance on push / pop, wrapping naturally.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Pointer registers; reset discards whatever was held.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone
    // decide which entries are meaningful, and an unreset array maps to RAM.
    if (push) mem_q[wr_ptr_q[IDX_W-1:0]] <= {push_addr, push_data};
  end

  // Occupancy, status flags, head entry and per-entry valid vector.
  always_comb begin
    count      = wr_ptr_q - rd_ptr_q;
    full       = (count == PTR_W'(DEPTH));
    empty      = (count == '0);
    head_addr  = mem_q[rd_ptr_q[IDX_W-1:0]].addr;
    head_data  = mem_q[rd_ptr_q[IDX_W-1:0]].data;
    entry_vld  = '0;
    entry_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Distance from the head, modulo DEPTH; valid if inside the occupied span.
      rel[i] = IDX_W'(i) - rd_ptr_q[IDX_W-1:0];
      entry_vld[i] = ({1'b0, rel[i]} < count);
      entry_addr[i*ADDR_W +: ADDR_W] = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of register_file: buffers (addr, data) writes,
// drains at most one per cycle through a registered write port, and flags
// read-after-write hazards for up to two operand addresses.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   drain_en,
  output logic                   rf_ce,
  output logic                   rf_wr_en,
  output logic [ADDR_W-1:0]      rf_wr_addr,
  output logic [DATA_W-1:0]      rf_wr_data,
  input  logic [ADDR_W-1:0]      chk_addr1,
  input  logic [ADDR_W-1:0]      chk_addr2,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  logic                    push, pop;
  logic [ADDR_W-1:0]       head_addr;
  logic [DATA_W-1:0]       head_data;
  logic [DEPTH*ADDR_W-1:0] entry_addr;
  logic [DEPTH-1:0]        entry_vld;

  logic                    rf_ce_q,      rf_ce_d;
  logic                    rf_wr_en_q,   rf_wr_en_d;
  logic [ADDR_W-1:0]       rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_W-1:0]       rf_wr_data_q, rf_wr_data_d;

  // A full queue refuses input even if it drains this cycle (no pass-through).
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && drain_en;

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .push_addr  (in_addr),
    .push_data  (in_data),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .entry_addr (entry_addr),
    .entry_vld  (entry_vld),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // Output stage: a one-cycle write pulse per popped entry; addr/data hold.
  always_comb begin
    rf_ce_d      = 1'b1;
    rf_wr_en_d   = pop;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    if (pop) begin
      rf_wr_addr_d = head_addr;
      rf_wr_data_d = head_data;
    end
  end

  // Output stage registers; rf_ce rises on the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_ce_q      <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      rf_ce_q      <= rf_ce_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign rf_ce      = rf_ce_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;

  // Hazard comparators: queued entries, the in-flight write, and this cycle's push.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entry_addr[i*ADDR_W +: ADDR_W] == chk_addr1)) hazard1 = 1'b1;
      if (entry_vld[i] && (entry_addr[i*ADDR_W +: ADDR_W] == chk_addr2)) hazard2 = 1'b1;
    end
    if (rf_wr_en_q && (rf_wr_addr_q == chk_addr1)) hazard1 = 1'b1;
    if (rf_wr_en_q && (rf_wr_addr_q == chk_addr2)) hazard2 = 1'b1;
    if (push && (in_addr == chk_addr1)) hazard1 = 1'b1;
    if (push && (in_addr == chk_addr2)) hazard2 = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus a randomized run,
// checked against a queue-based reference model and a simple register file.
module tb_regfile_wb_queue;
  import regfile_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_addr = '0;
  logic [31:0]   in_data = '0;
  logic          drain_en = 1'b0;
  logic          rf_ce, rf_wr_en;
  logic [4:0]    rf_wr_addr;
  logic [31:0]   rf_wr_data;
  logic [4:0]    chk_addr1 = '0, chk_addr2 = '0;
  logic          hazard1, hazard2;
  logic [CW-1:0] count;
  logic          empty, full;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en),
    .rf_ce(rf_ce), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hazard1(hazard1), .hazard2(hazard2),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Downstream register file: captures the write port on each rising edge.
  logic [31:0] rf_mem [32];
  int          dut_wr_cnt = 0;
  always @(posedge clk) begin
    if (rf_ce && rf_wr_en) begin
      rf_mem[rf_wr_addr] <= rf_wr_data;
      dut_wr_cnt         <= dut_wr_cnt + 1;
    end
  end

  // Reference model: an ordered list of pending writes plus the output stage.
  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic model_reset();
    mq.delete();
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Apply one clock edge's worth of queue behaviour using the current inputs.
  task automatic model_edge();
    bit   acc, pop;
    ent_t e;
    acc  = in_valid && (mq.size() < DEPTH);
    pop  = drain_en && (mq.size() > 0);
    m_en = pop;
    if (pop) begin
      e      = mq.pop_front();
      m_addr = e.a;
      m_data = e.d;
    end
    if (acc) begin
      e.a = in_addr;
      e.d = in_data;
      mq.push_back(e);
    end
  endtask

  function automatic bit exp_hz(input logic [4:0] a);
    exp_hz = 1'b0;
    foreach (mq[i]) if (mq[i].a == a) exp_hz = 1'b1;
    if (m_en && m_addr == a) exp_hz = 1'b1;
    if (in_valid && (mq.size() < DEPTH) && in_addr == a) exp_hz = 1'b1;
  endfunction

  // Advance one cycle; outputs settle by 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (count !== '0)       begin n_bad++; $display("FAIL reset_count got=%0d want=0", count); end
    n_cmp++; if (empty !== 1'b1)     begin n_bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    n_cmp++; if (full !== 1'b0)      begin n_bad++; $display("FAIL reset_full got=%b want=0", full); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (rf_wr_en !== 1'b0)  begin n_bad++; $display("FAIL reset_wr_en got=%b want=0", rf_wr_en); end
    n_cmp++; if (rf_ce !== 1'b0)     begin n_bad++; $display("FAIL reset_ce got=%b want=0", rf_ce); end
    n_cmp++; if ({rf_wr_addr, rf_wr_data} !== '0) begin n_bad++; $display("FAIL reset_wr_bus got=%h/%h want=0/0", rf_wr_addr, rf_wr_data); end
    rst_n = 1'b1;
    model_reset();
    tick();
    n_cmp++; if (rf_ce !== 1'b1)     begin n_bad++; $display("FAIL ce_after_reset got=%b want=1", rf_ce); end
  endtask

  task automatic test_single();
    drain_en = 1'b1;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (rf_wr_en !== 1'b0)  begin n_bad++; $display("FAIL single_edge1_wr_en got=%b want=0", rf_wr_en); end
    n_cmp++; if (count !== CW'(1))   begin n_bad++; $display("FAIL single_count got=%0d want=1", count); end
    tick();
    n_cmp++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_write got=%b/%0d/%h want=1/7/deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    tick();
    n_cmp++; if (rf_wr_en !== 1'b0)  begin n_bad++; $display("FAIL single_pulse_len got=%b want=0", rf_wr_en); end
    n_cmp++; if (rf_mem[7] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_rf_read got=%h want=deadbeef", rf_mem[7]); end
  endtask

  task automatic test_full();
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'h10 + 32'(i);
      tick();
    end
    n_cmp++; if (full !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL full_flags got full=%b rdy=%b want 1/0", full, in_ready); end
    in_addr = 5'd31; in_data = 32'hFFFFFFFF;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (count !== CW'(4))   begin n_bad++; $display("FAIL full_5th_ignored count got=%0d want=4", count); end
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'(i) || rf_wr_data !== 32'h10 + 32'(i)) begin
        n_bad++; $display("FAIL full_drain_%0d got=%b/%0d/%h want=1/%0d/%h", i, rf_wr_en, rf_wr_addr, rf_wr_data, i, 32'h10 + 32'(i));
      end
    end
    n_cmp++; if (empty !== 1'b1)     begin n_bad++; $display("FAIL full_then_empty got=%b want=1", empty); end
    tick();
    n_cmp++; if (rf_wr_en !== 1'b0)  begin n_bad++; $display("FAIL full_no_extra_write got=%b want=0", rf_wr_en); end
  endtask

  task automatic test_back_to_back();
    drain_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_addr = 5'($urandom_range(31, 0)); in_data = $urandom();
      tick();
    end
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_addr = 5'($urandom_range(31, 0)); in_data = $urandom();
      tick();
      n_cmp++; if (count !== CW'(2)) begin n_bad++; $display("FAIL b2b_count_%0d got=%0d want=2", i, count); end
      n_cmp++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== m_addr || rf_wr_data !== m_data) begin
        n_bad++; $display("FAIL b2b_order_%0d got=%b/%0d/%h want=1/%0d/%h", i, rf_wr_en, rf_wr_addr, rf_wr_data, m_addr, m_data);
      end
    end
    in_valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL b2b_drained got=%b want=1", empty); end
  endtask

  task automatic test_hazard();
    drain_en = 1'b0;
    chk_addr1 = 5'd12; chk_addr2 = 5'd13;
    in_valid = 1'b1; in_addr = 5'd12; in_data = 32'hC0FFEE12;
    #1;
    n_cmp++; if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin n_bad++; $display("FAIL hz_input got=%b%b want=10", hazard1, hazard2); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin n_bad++; $display("FAIL hz_queued got=%b%b want=10", hazard1, hazard2); end
    drain_en = 1'b1;
    tick();
    n_cmp++; if (rf_wr_en !== 1'b1 || hazard1 !== 1'b1) begin n_bad++; $display("FAIL hz_inflight got en=%b hz=%b want 1/1", rf_wr_en, hazard1); end
    tick();
    n_cmp++; if (rf_wr_en !== 1'b0 || hazard1 !== 1'b0) begin n_bad++; $display("FAIL hz_cleared got en=%b hz=%b want 0/0", rf_wr_en, hazard1); end
    n_cmp++; if (rf_mem[12] !== 32'hC0FFEE12) begin n_bad++; $display("FAIL hz_rf_read got=%h want=c0ffee12", rf_mem[12]); end
  endtask

  task automatic test_duplicate();
    drain_en = 1'b1;
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'hAAAA0000;
    tick();
    in_data = 32'h5555FFFF;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 32'hAAAA0000) begin
      n_bad++; $display("FAIL dup_first got=%b/%0d/%h want=1/3/aaaa0000", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    tick();
    n_cmp++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 32'h5555FFFF) begin
      n_bad++; $display("FAIL dup_second got=%b/%0d/%h want=1/3/5555ffff", rf_wr_en, rf_wr_addr, rf_wr_data);
    end
    tick();
    n_cmp++; if (rf_mem[3] !== 32'h5555FFFF) begin n_bad++; $display("FAIL dup_final_read got=%h want=5555ffff", rf_mem[3]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(1, 0));
      drain_en  = ($urandom_range(3, 0) != 0);
      in_addr   = 5'($urandom_range(7, 0));
      in_data   = $urandom();
      chk_addr1 = 5'($urandom_range(7, 0));
      chk_addr2 = 5'($urandom_range(7, 0));
      #1;
      n_cmp++; if (count !== CW'(mq.size()) || full !== (mq.size() == DEPTH) ||
                   empty !== (mq.size() == 0) || in_ready !== (mq.size() < DEPTH)) begin
        n_bad++; $display("FAIL rnd_status_%0d got cnt=%0d f=%b e=%b r=%b want cnt=%0d", i, count, full, empty, in_ready, mq.size());
      end
      n_cmp++; if (hazard1 !== exp_hz(chk_addr1) || hazard2 !== exp_hz(chk_addr2)) begin
        n_bad++; $display("FAIL rnd_hazard_%0d got=%b%b want=%b%b", i, hazard1, hazard2, exp_hz(chk_addr1), exp_hz(chk_addr2));
      end
      tick();
      n_cmp++; if (rf_wr_en !== m_en || (m_en && (rf_wr_addr !== m_addr || rf_wr_data !== m_data))) begin
        n_bad++; $display("FAIL rnd_write_%0d got=%b/%0d/%h want=%b/%0d/%h", i, rf_wr_en, rf_wr_addr, rf_wr_data, m_en, m_addr, m_data);
      end
    end
    in_valid = 1'b0;
    drain_en = 1'b1;
    repeat (DEPTH + 2) tick();
  endtask

  task automatic test_reset_mid();
    int w0;
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = 5'(20 + i); in_data = 32'hBAD00000 + 32'(i);
      tick();
    end
    in_addr = 5'd9; chk_addr1 = 5'd9; chk_addr2 = 5'd20;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== '0 || rf_wr_en !== 1'b0 || rf_ce !== 1'b0) begin
      n_bad++; $display("FAIL midrst_immediate got cnt=%0d en=%b ce=%b want 0/0/0", count, rf_wr_en, rf_ce);
    end
    n_cmp++; if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin n_bad++; $display("FAIL midrst_hazard got=%b%b want=10", hazard1, hazard2); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    w0 = dut_wr_cnt;
    drain_en = 1'b1;
    repeat (6) tick();
    n_cmp++; if (dut_wr_cnt !== w0 || count !== '0) begin
      n_bad++; $display("FAIL midrst_discarded got writes=%0d cnt=%0d want writes=%0d cnt=0", dut_wr_cnt, count, w0);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_hazard();
    test_duplicate();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
